// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 control FSM: state encoding,
// opcodes, datapath select codes and trap cause codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECR,
        ST_EXECI,
        ST_ALUWB,
        ST_BEQ,
        ST_JAL,
        ST_TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    // States that wait on the memory handshake and are subject to the bus timeout.
    function automatic logic is_mem_wait(state_e s);
        return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
    endfunction

endpackage

// File: rtl/imm_src_decode.sv
// Immediate-format select decoded directly from the opcode; I-type for
// anything not listed.
module imm_src_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // Opcode to immediate format lookup.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves imm_src unassigned (no latch).
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle RV32 core. Steps
// fetch/decode/execute/memory/writeback, drives datapath selects and enables,
// and traps on an illegal opcode or a memory handshake timeout.
// Optional feature: define MC_CTRL_PERF_EN to add cycle_cnt / instret_cnt.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             reg_write,
    output logic             trap,
    output logic [1:0]       trap_cause
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    // Timeout fires when the counter would reach MEM_WAIT_MAX on this stalled cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] trap_cause_q, trap_cause_d;
    logic       timeout;

    imm_src_decode u_imm_src_decode (
        .op      (op),
        .imm_src (imm_src)
    );

    // Next-state, trap cause capture and memory wait counter.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        timeout      = is_mem_wait(state_q) && !mem_ready && (wait_cnt_q == WAIT_LAST);
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_RTYPE:          state_d = ST_EXECR;
                    OP_ITYPE:          state_d = ST_EXECI;
                    OP_BRANCH:         state_d = ST_BEQ;
                    OP_JAL:            state_d = ST_JAL;
                    default: begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR:   state_d = op[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXECR:    state_d = ST_ALUWB;
            ST_EXECI:    state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BEQ:      state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase
        if (timeout) begin
            state_d      = ST_TRAP;
            trap_cause_d = CAUSE_BUS;
        end
        if (!is_mem_wait(state_q) || mem_ready || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // FSM state register with asynchronous reset into FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Moore output decode; only FETCH (mem_ready) and BEQ (zero) look at inputs.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_ADD;
        case (state_q)
            ST_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEMREAD:  adr_src = 1'b1;
            ST_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_ALUWB:    reg_write = 1'b1;
            ST_BEQ: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_SUB;
                pc_write  = zero;
            end
            ST_JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Enables are suppressed while reset is held, even if mem_ready is high in FETCH.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = trap_cause_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic             retire;

    // Counter next values: cycles outside TRAP, retirements on return to FETCH.
    always_comb begin
        retire = (state_d == ST_FETCH) &&
                 ((state_q == ST_MEMWB) || (state_q == ST_MEMWRITE) ||
                  (state_q == ST_ALUWB) || (state_q == ST_BEQ));
        cycle_cnt_d   = (state_q != ST_TRAP) ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
        instret_cnt_d = retire ? instret_cnt_q + 1'b1 : instret_cnt_q;
    end

    // Performance counter registers, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    localparam int unsigned cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Each step pushes the expected
// output vector for the state the core should be in, then pops and compares
// it against the DUT after the inputs settle.
module tb_multicycle_control_fsm;

    typedef enum int {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } tb_state_e;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       trap;
        logic [1:0] trap_cause;
    } out_t;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] ILL  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap_cause;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [1:0] cur_cause = 2'b00;
    out_t       exp_q[$];
    string      tag_q[$];

    multicycle_control_fsm #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .trap       (trap),
        .trap_cause (trap_cause)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Expected outputs for a given state, straight from the state table.
    function automatic out_t expect_out(tb_state_e s, logic rdy, logic z, logic [6:0] o,
                                        logic [1:0] cause);
        out_t e;
        e = '0;
        case (o)
            SW:      e.imm_src = 2'b01;
            BEQ:     e.imm_src = 2'b10;
            JAL:     e.imm_src = 2'b11;
            default: e.imm_src = 2'b00;
        endcase
        e.trap_cause = cause;
        case (s)
            S_FETCH: begin
                e.alu_src_b = 2'b10; e.result_src = 2'b10;
                e.ir_write = rdy; e.pc_write = rdy;
            end
            S_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            S_MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            S_MEMREAD:  e.adr_src = 1'b1;
            S_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            S_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            S_EXECR:    begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
            S_EXECI:    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            S_ALUWB:    e.reg_write = 1'b1;
            S_BEQ:      begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
            S_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            S_TRAP:     e.trap = 1'b1;
            default:    ;
        endcase
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic compare_next();
        out_t  obs;
        out_t  e;
        string t;
        obs = '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                alu_op, imm_src, reg_write, trap, trap_cause};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_val(t, 32'(obs), 32'(e));
    endtask

    // One clock of stimulus: drive inputs, queue the expectation, compare.
    task automatic step(input string tag, input tb_state_e s, input logic rdy, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(expect_out(s, rdy, z, op, cur_cause));
        tag_q.push_back(tag);
        #1;
        compare_next();
    endtask

    task automatic check_counters_zero(input string tag);
`ifdef MC_CTRL_PERF_EN
        check_val({tag, " cycle_cnt"}, cycle_cnt, 32'd0);
        check_val({tag, " instret_cnt"}, instret_cnt, 32'd0);
`endif
    endtask

    task automatic check_instret(input string tag, input int n);
`ifdef MC_CTRL_PERF_EN
        check_val(tag, instret_cnt, 32'(n));
`endif
    endtask

    // Hold reset with mem_ready high: enables must stay low, FETCH decode shown.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        cur_cause = 2'b00;
        #1;
        exp_q.push_back(expect_out(S_FETCH, 1'b0, 1'b0, op, cur_cause));
        tag_q.push_back(tag);
        compare_next();
        check_counters_zero(tag);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        op        = LW;
        reset_pulse("reset");

        // lw with mem_ready high throughout
        op = LW;
        step("lw fetch",   S_FETCH,   1, 0);
        step("lw decode",  S_DECODE,  1, 0);
        step("lw memadr",  S_MEMADR,  1, 0);
        step("lw memread", S_MEMREAD, 1, 0);
        step("lw memwb",   S_MEMWB,   1, 0);

        // sw stalled three cycles in MEMWRITE
        op = SW;
        step("sw fetch",  S_FETCH,  1, 0);
        check_instret("instret after lw", 1);
        step("sw decode", S_DECODE, 0, 0);
        step("sw memadr", S_MEMADR, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("sw memwrite stall%0d", i), S_MEMWRITE, 0, 0);
        step("sw memwrite done", S_MEMWRITE, 1, 0);

        // beq taken then not taken
        op = BEQ;
        step("beq1 fetch",  S_FETCH,  1, 0);
        check_instret("instret after sw", 2);
        step("beq1 decode", S_DECODE, 1, 1);
        step("beq1 taken",  S_BEQ,    1, 1);
        step("beq0 fetch",  S_FETCH,  1, 0);
        step("beq0 decode", S_DECODE, 1, 0);
        step("beq0 not taken", S_BEQ, 1, 0);

        // add, addi, jal
        op = ADD;
        step("add fetch",  S_FETCH,  1, 0);
        check_instret("instret after beq", 4);
        step("add decode", S_DECODE, 1, 0);
        step("add execr",  S_EXECR,  1, 0);
        step("add aluwb",  S_ALUWB,  1, 0);
        op = ADDI;
        step("addi fetch",  S_FETCH,  1, 0);
        step("addi decode", S_DECODE, 1, 0);
        step("addi execi",  S_EXECI,  1, 0);
        step("addi aluwb",  S_ALUWB,  1, 0);
        op = JAL;
        step("jal fetch",  S_FETCH,  1, 0);
        step("jal decode", S_DECODE, 1, 0);
        step("jal jal",    S_JAL,    1, 0);
        step("jal aluwb",  S_ALUWB,  1, 0);

        // mem_ready arrives on the last allowed cycle: no trap
        op = ADD;
        for (int i = 0; i < 14; i++) step($sformatf("near fetch wait%0d", i), S_FETCH, 0, 0);
        step("near fetch ready", S_FETCH, 1, 0);
        check_instret("instret after jal", 7);
        step("near decode", S_DECODE, 1, 0);
        step("near execr",  S_EXECR,  0, 0);
        step("near aluwb",  S_ALUWB,  0, 0);

        // fifteen stalled cycles in FETCH: bus timeout
        for (int i = 0; i < 15; i++) step($sformatf("timeout fetch wait%0d", i), S_FETCH, 0, 0);
        cur_cause = 2'b10;
        for (int i = 0; i < 3; i++) step($sformatf("timeout trap%0d", i), S_TRAP, i[0], 1);
        check_instret("instret frozen in trap", 8);
        reset_pulse("reset after timeout");

        // illegal opcode: trap held for 20 cycles regardless of inputs
        op = ILL;
        step("ill fetch",  S_FETCH,  1, 0);
        step("ill decode", S_DECODE, 1, 0);
        cur_cause = 2'b01;
        for (int i = 0; i < 20; i++) step($sformatf("ill trap%0d", i), S_TRAP, i[0], i[1]);
        reset_pulse("reset after illegal");
        step("post reset fetch", S_FETCH, 0, 0);

        // reset asserted mid MEMWRITE drops mem_write without a clock edge
        op = SW;
        step("rst sw fetch",  S_FETCH,  1, 0);
        step("rst sw decode", S_DECODE, 0, 0);
        step("rst sw memadr", S_MEMADR, 0, 0);
        step("rst sw memwrite", S_MEMWRITE, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async mem_write", {31'd0, mem_write}, 32'd0);
        exp_q.push_back(expect_out(S_FETCH, 1'b0, 1'b0, op, cur_cause));
        tag_q.push_back("async reset outputs");
        compare_next();
        @(negedge clk);
        rst_n = 1'b1;
        step("after async reset fetch", S_FETCH, 0, 0);
        check_counters_zero("after async reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
